// File: rtl/rom_rd_arbiter_if.sv
// Signal bundle between the two ROM read requesters, the arbiter and the ROM.
// The master side drives the requests and the ROM read data; the arbiter is the slave.
interface rom_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rd_data;

  modport master (
    output req0, addr0, req1, addr1, rom_rd_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport slave (
    input  req0, addr0, req1, addr1, rom_rd_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );
endinterface

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between instruction fetch (port 0)
// and data-side constant load (port 1); a tag pipeline routes each word back to its issuer.
module rom_rd_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rom_rd_arbiter_if.slave    io_bus
);

  logic                  r_last_gnt;
  logic [RD_LATENCY-1:0] r_tag_valid;
  logic [RD_LATENCY-1:0] r_tag_port;

  logic                  w_winner;
  logic                  w_grant_valid;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic                  w_resp_valid;
  logic                  w_resp_port;
  logic                  w_rvalid0;
  logic                  w_rvalid1;

  // Pick the winner; under contention the port that did not win last time gets it.
  // Grants are forced off while reset is asserted.
  always_comb begin
    w_winner      = 1'b0;
    w_grant_valid = 1'b0;
    case ({io_bus.req1, io_bus.req0})
      2'b01: begin
        w_winner      = 1'b0;
        w_grant_valid = ~i_rst;
      end
      2'b10: begin
        w_winner      = 1'b1;
        w_grant_valid = ~i_rst;
      end
      2'b11: begin
        w_winner      = ~r_last_gnt;
        w_grant_valid = ~i_rst;
      end
      default: begin
        w_winner      = 1'b0;
        w_grant_valid = 1'b0;
      end
    endcase
  end

  // Steer the winning address to the ROM; idle cycles present address zero.
  always_comb begin
    w_rom_addr = {ADDR_WIDTH{1'b0}};
    if (w_grant_valid) begin
      if (w_winner) begin
        w_rom_addr = io_bus.addr1;
      end else begin
        w_rom_addr = io_bus.addr0;
      end
    end else begin
      w_rom_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  // Remember the most recent winner for round-robin fairness.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_grant_valid) begin
      r_last_gnt <= w_winner;
    end else begin
      r_last_gnt <= r_last_gnt;
    end
  end

  // Tag pipeline tracks {valid, port} of each read alongside the ROM latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_valid <= {RD_LATENCY{1'b0}};
      r_tag_port  <= {RD_LATENCY{1'b0}};
    end else begin
      r_tag_valid[0] <= w_grant_valid;
      r_tag_port[0]  <= w_winner;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_tag_valid[k] <= r_tag_valid[k-1];
        r_tag_port[k]  <= r_tag_port[k-1];
      end
    end
  end

  assign w_resp_valid = r_tag_valid[RD_LATENCY-1];
  assign w_resp_port  = r_tag_port[RD_LATENCY-1];
  assign w_rvalid0    = w_resp_valid & ~w_resp_port;
  assign w_rvalid1    = w_resp_valid &  w_resp_port;

  assign io_bus.gnt0     = w_grant_valid & ~w_winner;
  assign io_bus.gnt1     = w_grant_valid &  w_winner;
  assign io_bus.rom_addr = w_rom_addr;
  assign io_bus.rvalid0  = w_rvalid0;
  assign io_bus.rvalid1  = w_rvalid1;
  // Read data is zeroed on the port that is not being answered.
  assign io_bus.rdata0   = w_rvalid0 ? io_bus.rom_rd_data : {DATA_WIDTH{1'b0}};
  assign io_bus.rdata1   = w_rvalid1 ? io_bus.rom_rd_data : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares the single-port 32-bit x 1024 instruction ROM between two read requesters: port 0 (instruction fetch) and port 1 (data-side constant load).
- Arbitrates round-robin at one grant per cycle and drives the ROM address.
- Tracks in-flight reads through a tag pipeline matched to the ROM read latency, and routes each returning word to the requester that issued it.
- Sits between the core's fetch/load units and the ROM IP wrapper.

Parameters:
- ADDR_WIDTH, 10, word-address width of the ROM.
- DATA_WIDTH, 32, ROM word width.
- RD_LATENCY, 1, cycles from the address-sampling edge to valid rom_rd_data. Legal values: 1 (no ROM output register) or 2 (ROM output register enabled).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req0, input, 1, port 0 read request; held until gnt0.
- addr0, input, ADDR_WIDTH, port 0 word address; stable while req0=1.
- gnt0, output, 1, port 0 request accepted this cycle.
- rvalid0, output, 1, port 0 read data valid (1-cycle pulse).
- rdata0, output, DATA_WIDTH, port 0 read data.
- req1, addr1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- rom_addr, output, ADDR_WIDTH, address to the ROM.
- rom_rd_data, input, DATA_WIDTH, data from the ROM.

Behaviour:
- Arbitration is combinational from req0, req1 and the last_gnt register:
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to last_gnt wins.
  - No request: no grant.
  - At most one of gnt0/gnt1 is high in any cycle; gntN never asserts without reqN.
- rom_addr = winner's address; 0 when there is no grant. The ROM samples rom_addr on the same edge that completes the grant.
- last_gnt updates to the winner on every granted cycle and holds otherwise. Reset value is 1, so port 0 wins the first contention.
- Tag pipeline: RD_LATENCY stages, each holding {valid, port}.
  - Stage 0 loads {grant_valid, winner} each cycle.
  - Stage k loads stage k-1.
  - The last stage is the response stage.
- Response:
  - rvalidN = response.valid and response.port == N.
  - rdataN = rom_rd_data when rvalidN = 1, else 0.
  - Latency: a grant at edge E yields rvalidN high during the cycle after edge E+RD_LATENCY-1. For RD_LATENCY=1, rvalid arrives in the cycle immediately following the grant cycle.
- Throughput:
  - One read issued per cycle and one response per cycle; back-to-back grants to the same port are allowed.
  - With both ports requesting continuously, grants alternate 0,1,0,1…
- No backpressure on responses. Requesters must accept rvalid in the cycle it is asserted. Responses return in issue order.
- A requester may raise a new req in the same cycle its previous rvalid arrives, or earlier (pipelined use).
- Boundary cases:
  - Address 0 and address 2^ADDR_WIDTH-1 pass through unchanged; there is no wrap or bounds check.
  - reqN dropped before gntN is legal; no state is retained for that request.
  - Port 1 requesting alone repeatedly while port 0 is idle gets every cycle. Fairness applies only under contention.
- Reset (asynchronous):
  - Clears all tag-pipeline valids and sets last_gnt=1.
  - All outputs go low or 0 immediately: gnt0/1=0 because the grant outputs are gated by reset, rvalid0/1=0, rdata0/1=0, rom_addr=0.
  - In-flight reads at reset assertion are discarded and never produce rvalid after reset release.
- Invariant: in every cycle, the number of rvalid pulses equals the number of grants issued RD_LATENCY cycles earlier.

Test Plan:
- ROM preloaded with word[i]=i+0x1000. RD_LATENCY=1. req0=1, addr0=5 for one cycle → gnt0=1 that cycle; next cycle rvalid0=1, rdata0=0x1005; rvalid1=0 throughout.
- req0 and req1 held for 6 cycles with addr0=2, addr1=3, first grant after reset → grants 0,1,0,1,0,1. rvalid sequence lags by 1 cycle with rdata 0x1002/0x1003 routed to the matching port.
- req1 alone for 4 consecutive cycles, addr1=0,1,2,1023 → gnt1 high all 4 cycles; rdata1 = 0x1000, 0x1001, 0x1002, 0x13FF on the next 4 cycles.
- RD_LATENCY=2, single req0 at addr 7 → rvalid0 exactly 2 cycles after the gnt0 cycle with rdata0=0x1007. Continuous alternating traffic sustains 1 response per cycle.
- Assert rst asynchronously one cycle after a gnt0 (read in flight) → rvalid0/1, gnt0/1, rom_addr go 0 immediately; no rvalid after release. First contention after release grants port 0.
- req0 raised then dropped while port 1 wins contention → no gnt0 and no rvalid0 is produced; port 1 is served normally.
